// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// the latched request payload and the access-legality rule.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_ADDR = 3'd1,
    ST_LD_DATA = 3'd2,
    ST_ST_WR   = 3'd3,
    ST_RMW_RD  = 3'd4,
    ST_RMW_WR  = 3'd5
  } lsu_state_e;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  // Misaligned halfword/word, reserved funct3, or an unsigned-store encoding.
  function automatic logic lsu_is_error(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = is_store;
      F3_HU:   err = is_store | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the LSU: load extraction/extension, store byte mask and
// the read-modify-write merged word. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] repl;
  logic [31:0] bm;

  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'h0, byte_lane};
      F3_HU:   load_data_o = {16'h0, half_lane};
      default: load_data_o = 32'h0;
    endcase
  end

  // Store size comes from funct3[1:0]; unsigned encodings never reach a write.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wmask_o = 4'b0001 << addr_lo_i;
        repl    = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wmask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        repl    = {2{wdata_i[15:0]}};
      end
      default: begin
        wmask_o = 4'b1111;
        repl    = wdata_i;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      bm[8*i +: 8] = {8{wmask_o[i]}};
    end
    merged_o = (rdata_i & ~bm) | (repl & bm);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed loads/stores into word accesses on a
// 1-cycle registered-read data memory, using read-modify-write for SB/SH.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned BA_W = ADDR_WIDTH + 2;

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_mis_q, resp_mis_d;

  logic [31:0]       load_data;
  logic [3:0]        align_wmask;
  logic [31:0]       merged_word;

  // Byte address bits above the memory size wrap silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:BA_W];

  lsu_align u_align (
    .funct3_i    (req_q.funct3),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (req_q.wdata),
    .rdata_i     (mem_rdata),
    .load_data_o (load_data),
    .wmask_o     (align_wmask),
    .merged_o    (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
    end
  end

  // Next state and response; illegal accesses answer from IDLE without a memory cycle.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_mis_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d  = '{is_store: req_is_store, funct3: req_funct3, wdata: req_wdata};
          addr_d = req_addr[BA_W-1:0];
          if (lsu_is_error(req_is_store, req_funct3, req_addr[1:0])) begin
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
          end else if (!req_is_store) begin
            state_d = ST_LD_ADDR;
          end else if (req_funct3 == F3_W) begin
            state_d = ST_ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LD_ADDR: state_d = ST_LD_DATA;
      ST_LD_DATA: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
        state_d      = ST_IDLE;
      end
      ST_ST_WR: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes decode the state directly; reset suppresses any write in flight.
  always_comb begin
    mem_we    = rst_n & ((state_q == ST_ST_WR) | (state_q == ST_RMW_WR));
    mem_wmask = mem_we ? align_wmask : 4'b0000;
    mem_wdata = (state_q == ST_RMW_WR) ? merged_word : req_q.wdata;
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign mem_addr        = addr_q[BA_W-1:2];
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;

endmodule
